// File: rtl/dmem_init_loader_if.sv
// Byte-stream input and data-memory init write port of the program loader.
// The env side (master) feeds bytes and stall; the loader (slave) writes.
interface dmem_init_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        dmem_stall;
  logic [3:0]  dmem_init_wen;
  logic [31:0] dmem_init_addr;
  logic [31:0] dmem_init_data;

  modport master (
    output rx_valid,
    output rx_data,
    output dmem_stall,
    input  rx_ready,
    input  dmem_init_wen,
    input  dmem_init_addr,
    input  dmem_init_data
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  dmem_stall,
    output rx_ready,
    output dmem_init_wen,
    output dmem_init_addr,
    output dmem_init_data
  );
endinterface

// File: rtl/dmem_init_loader.sv
// Length-prefixed byte-stream loader: assembles LE words and writes them
// into data memory through the init port, then hands memory to the core.
module dmem_init_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  dmem_init_loader_if.slave    bus,
  output logic                 o_dmem_init_done,
  output logic                 o_error,
  output logic [CNT_WIDTH-1:0] o_word_count
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [31:0]          word_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [31:0]          addr_q;
  logic [3:0]           wen_q;
  logic                 done_q;
  logic                 err_q;

  logic                 rx_ready;
  logic                 take;
  logic [31:0]          shift_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [31:0]          addr_d;

  assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign take     = bus.rx_valid && rx_ready;
  // Bytes arrive LSB first, so each one enters at the top and shifts down.
  assign shift_d  = {bus.rx_data, word_q[31:8]};
  assign cnt_d    = cnt_q + CNT_WIDTH'(1);
  assign addr_d   = addr_q + 32'd4;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_HDR;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wen_q   <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_HDR: begin
          if (take) begin
            word_q <= shift_d;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              len_q <= CNT_WIDTH'(shift_d);
              if (shift_d == 32'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else if (shift_d > 32'(MAX_WORDS)) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (take) begin
            word_q <= shift_d;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_WRITE;
              wen_q   <= 4'b1111;
            end
          end
        end
        S_WRITE: begin
          // Dropping wen on the accept edge prevents a duplicate write.
          if (!bus.dmem_stall) begin
            wen_q  <= 4'b0000;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            if (cnt_d == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_HDR;
        end
      endcase
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.dmem_init_wen  = wen_q;
  assign bus.dmem_init_addr = addr_q;
  assign bus.dmem_init_data = word_q;
  assign o_dmem_init_done   = done_q;
  assign o_error            = err_q;
  assign o_word_count       = cnt_q;

endmodule
